// File: rtl/serdes_pkg.sv
// serdes_pkg: output-FSM state type and width-ratio helpers shared by the serializer and deserializer.
package serdes_pkg;

    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

    function automatic int num_segments(input int narrow_w, input int wide_w);
        return wide_w / narrow_w;
    endfunction

    function automatic bit ratio_ok(input int narrow_w, input int wide_w);
        int n;
        n = (narrow_w > 0) ? wide_w / narrow_w : 0;
        return narrow_w > 0 && wide_w % narrow_w == 0 && n >= 2 && (n & (n - 1)) == 0;
    endfunction

endpackage

// File: rtl/deserializer.sv
// deserializer: rebuilds wide words from narrow segments (segment 0 in the LSBs)
// and holds each word in a registered output until the consumer acks it.
module deserializer
    import serdes_pkg::*;
#(
    parameter int in_bit_width  = 32,
    parameter int out_bit_width = 512
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     data_valid,
    input  logic [in_bit_width-1:0]  data_in,
    input  logic                     flush,
    output logic                     word_valid,
    input  logic                     word_ack,
    output logic [out_bit_width-1:0] data_out,
    output logic                     overrun
);

    localparam int num_segs   = num_segments(in_bit_width, out_bit_width);
    localparam int seg_ctr_bw = $clog2(num_segs);

    if (!ratio_ok(in_bit_width, out_bit_width)) begin : g_bad_ratio
        $error("deserializer: out_bit_width must be a power-of-2 multiple (>=2) of in_bit_width");
    end

    logic [seg_ctr_bw-1:0]    seg_cnt_q, seg_cnt_d;
    logic [in_bit_width-1:0]  asm_buf_q [num_segs-1];
    logic [num_segs-2:0]      seg_we;
    logic [out_bit_width-1:0] word_d, data_out_q;
    out_state_t               state_q;
    logic                     overrun_q;
    logic                     accept, complete;

    assign accept    = data_valid && !flush;
    assign complete  = accept && (&seg_cnt_q);
    assign seg_cnt_d = flush ? '0 : data_valid ? seg_cnt_q + seg_ctr_bw'(1) : seg_cnt_q;

    // The final segment is never stored: it goes straight from data_in into the word.
    always_comb begin
        word_d = '0;
        for (int j = 0; j < num_segs - 1; j++) word_d[j*in_bit_width +: in_bit_width] = asm_buf_q[j];
        word_d[out_bit_width-1 -: in_bit_width] = data_in;
    end

    for (genvar i = 0; i < num_segs - 1; i++) begin : g_slice
        assign seg_we[i] = accept && seg_cnt_q == seg_ctr_bw'(i);
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) asm_buf_q[i] <= '0;
            else if (seg_we[i]) asm_buf_q[i] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_cnt_q  <= '0;
            state_q    <= OUT_EMPTY;
            data_out_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            seg_cnt_q <= seg_cnt_d;
            case (state_q)
                OUT_EMPTY: if (complete) begin
                    data_out_q <= word_d;
                    state_q    <= OUT_FULL;
                end
                OUT_FULL: begin
                    if (complete && word_ack) data_out_q <= word_d;
                    else if (complete) overrun_q <= 1'b1;
                    else if (word_ack) state_q <= OUT_EMPTY;
                end
                default: state_q <= OUT_EMPTY;
            endcase
            if (flush) overrun_q <= 1'b0;
        end
    end

    assign word_valid = state_q == OUT_FULL;
    assign data_out   = data_out_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed stimulus with a word scoreboard checked by a negedge monitor.
module tb_deserializer;

    localparam int IW = 32;
    localparam int OW = 512;
    localparam int NS = OW / IW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          data_valid = 1'b0;
    logic [IW-1:0] data_in = '0;
    logic          flush = 1'b0;
    logic          word_ack = 1'b0;
    logic          word_valid, overrun;
    logic [OW-1:0] data_out;

    deserializer #(.in_bit_width(IW), .out_bit_width(OW)) dut (
        .clk(clk), .reset(reset), .data_valid(data_valid), .data_in(data_in),
        .flush(flush), .word_valid(word_valid), .word_ack(word_ack),
        .data_out(data_out), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail = 0;
    logic [OW-1:0] exp_q[$];

    function automatic logic [OW-1:0] mkword(input logic [IW-1:0] base);
        logic [OW-1:0] w;
        for (int i = 0; i < NS; i++) w[i*IW +: IW] = base + IW'(i);
        return w;
    endfunction

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [IW-1:0] v);
        data_valid = 1'b1;
        data_in = v;
        @(posedge clk); #1;
        data_valid = 1'b0;
    endtask

    task automatic send_word(input logic [IW-1:0] base, input int n);
        for (int i = 0; i < n; i++) send(base + IW'(i));
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic ack();
        word_ack = 1'b1;
        @(posedge clk); #1;
        word_ack = 1'b0;
    endtask

    // A word is newly presented when word_valid is high and the previous cycle did not merely hold it.
    logic prev_valid = 1'b0;
    logic prev_ack = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_valid = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (word_valid && (!prev_valid || prev_ack)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h expected none", data_out);
                end else check("scoreboard_word", data_out, exp_q.pop_front());
            end
            prev_valid = word_valid;
            prev_ack = word_ack;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_word_valid", word_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b1;
        idle(1);

        exp_q.push_back(mkword(32'h0));
        t0 = cyc;
        send_word(32'h0, 15);
        check("t1_wv_before_last", word_valid, 0);
        send(32'hF);
        check("t1_latency", OW'(cyc - t0), 16);
        check("t1_word_valid", word_valid, 1);
        check("t1_overrun", overrun, 0);
        check("t1_low_seg", data_out[31:0], 32'h0);
        check("t1_high_seg", data_out[511:480], 32'hF);
        ack();
        check("t1_ack_clears", word_valid, 0);

        exp_q.push_back(mkword(32'h0));
        t0 = cyc;
        for (int i = 0; i < NS; i++) begin
            send(IW'(i));
            if (i == 4 || i == 11) idle(3);
        end
        check("t2_latency", OW'(cyc - t0), 22);
        check("t2_word_valid", word_valid, 1);
        ack();

        exp_q.push_back(mkword(32'h100));
        exp_q.push_back(mkword(32'h200));
        send_word(32'h100, NS);
        send_word(32'h200, NS - 1);
        word_ack = 1'b1;
        send(32'h20F);
        word_ack = 1'b0;
        check("t3_word_valid", word_valid, 1);
        check("t3_overrun", overrun, 0);
        check("t3_data_out", data_out, mkword(32'h200));
        ack();
        check("t3_ack_clears", word_valid, 0);

        exp_q.push_back(mkword(32'h300));
        send_word(32'h300, NS);
        send_word(32'h400, NS - 1);
        check("t4_overrun_before", overrun, 0);
        send(32'h40F);
        check("t4_overrun_set", overrun, 1);
        check("t4_data_kept", data_out, mkword(32'h300));
        check("t4_word_valid", word_valid, 1);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        check("t4_flush_overrun", overrun, 0);
        check("t4_flush_wv", word_valid, 1);
        ack();
        check("t4_ack_clears", word_valid, 0);

        exp_q.push_back(mkword(32'hA0));
        send_word(32'h500, 7);
        flush = 1'b1;
        send(32'h507);
        flush = 1'b0;
        send_word(32'hA0, NS - 1);
        check("t5_no_partial", word_valid, 0);
        send(32'hAF);
        check("t5_word_valid", word_valid, 1);
        check("t5_low_seg", data_out[31:0], 32'hA0);

        send_word(32'h600, 9);
        check("t6_wv_before_rst", word_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_wv", word_valid, 0);
        check("t6_rst_data", data_out, 0);
        check("t6_rst_overrun", overrun, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.push_back(mkword(32'h700));
        send_word(32'h700, NS);
        check("t6_word_valid", word_valid, 1);
        check("t6_high_seg", data_out[511:480], 32'h70F);
        idle(2);
        check("scoreboard_drained", OW'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
